// File: rtl/mux_n_ne_1_pipe.sv
// mux_n_ne_1_pipe
// Registered N-channel, W-bit result selector for the 16-bit CPU datapath.
// On each accepted valid/ready transaction it selects one channel of `hyrjet`
// with `S` and stores it in a 2-entry skid buffer. The head entry is presented
// on `dalja`/`gabim` one cycle later. If `S` is out of range, the stored entry
// has data 0 and its error flag set. Backpressure depends only on registered
// occupancy, so no combinational path runs from out_ready or in_valid to
// in_ready.
module mux_n_ne_1_pipe #(
    parameter int W  = 16,  // width of each channel and of the output
    parameter int N  = 5,   // number of input channels, 2..2**SW
    parameter int SW = 3    // select width, 2**SW >= N
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [N*W-1:0] hyrjet,
    input  logic [SW-1:0]  S,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   dalja,
    output logic           gabim,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [1:0]     niveli
);

    // One buffered result: the selected data word plus its out-of-range flag.
    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
    } entry_t;

    // Buffer occupancy encodings. Occupancy is also the control state.
    localparam logic [1:0] LVL_EMPTY = 2'd0;
    localparam logic [1:0] LVL_ONE   = 2'd1;
    localparam logic [1:0] LVL_FULL  = 2'd2;

    // Registered state. `head` is always the oldest entry. `tail` holds the
    // second entry and is only meaningful when the buffer is full.
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [1:0] level_q, level_d;

    // Datapath and handshake helpers.
    entry_t     new_entry;
    logic       push;
    logic       pop;

    // Select the addressed channel; any select at or above N yields an error entry.
    // NOTE: every variable written in an always_comb gets a default on entry,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        new_entry      = '0;
        new_entry.err  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (S == SW'(k)) begin
                new_entry.data = hyrjet[k*W +: W];
                new_entry.err  = 1'b0;
            end
        end
    end

    // Handshakes. Both sides depend only on registered occupancy.
    assign in_ready  = (level_q != LVL_FULL);
    assign out_valid = (level_q != LVL_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Compute the next buffer contents from the push/pop pair.
    // Push and pop together can only happen at occupancy one: when full,
    // in_ready is low, and when empty, out_valid is low.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        case ({push, pop})
            2'b10: begin
                if (level_q == LVL_EMPTY) begin
                    head_d  = new_entry;
                    level_d = LVL_ONE;
                end else begin
                    tail_d  = new_entry;
                    level_d = LVL_FULL;
                end
            end
            2'b01: begin
                // Advance the queue. An unused tail is kept at zero, so a
                // buffer that drains to empty also leaves a zero head.
                head_d  = tail_q;
                tail_d  = '0;
                level_d = level_q - 2'd1;
            end
            2'b11: begin
                // Occupancy one: the outgoing head is replaced by the new entry.
                head_d  = new_entry;
            end
            default: begin
            end
        endcase
    end

    // Register buffer state. Synchronous reset discards both entries.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            // NOTE: the two data slots are reset along with occupancy. They
            // are tiny, and clearing them means no stale word can ever reach
            // dalja after a flush.
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= LVL_EMPTY;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    // Present the head entry only while it is valid; otherwise drive zeros.
    assign dalja  = out_valid ? head_q.data : '0;
    assign gabim  = out_valid ? head_q.err  : 1'b0;
    assign niveli = level_q;

endmodule

// File: tb/tb_mux_n_ne_1_pipe.sv
// Self-checking bench for mux_n_ne_1_pipe.
// Runs a directed vector table, two hand-written multi-cycle sequences, and a
// randomized phase compared against a queue-based reference model.
module tb_mux_n_ne_1_pipe;

    localparam int W  = 16;
    localparam int N  = 5;
    localparam int SW = 3;

    logic           Clock;
    logic           Reset;
    logic [N*W-1:0] hyrjet;
    logic [SW-1:0]  S;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   dalja;
    logic           gabim;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     niveli;

    int checks   = 0;
    int failures = 0;

    mux_n_ne_1_pipe #(.W(W), .N(N), .SW(SW)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .hyrjet   (hyrjet),
        .S        (S),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dalja    (dalja),
        .gabim    (gabim),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .niveli   (niveli)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Directed vector: inputs applied before an edge, outputs expected after it.
    typedef struct {
        bit          rst;
        bit          iv;
        bit [SW-1:0] s;
        bit          ordy;
        bit [1:0]    lvl;
        bit          ov;
        bit [W-1:0]  dat;
        bit          err;
        bit          ir;
    } vec_t;

    // Reference-model entry.
    typedef struct {
        logic [W-1:0] d;
        logic         e;
    } ref_t;

    vec_t vecs[$];
    ref_t model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] lvl, input logic ov,
                              input logic [W-1:0] dat, input logic err, input logic ir);
        check({tag, " niveli"},    32'(niveli),    32'(lvl));
        check({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, " dalja"},     32'(dalja),     32'(dat));
        check({tag, " gabim"},     32'(gabim),     32'(err));
        check({tag, " in_ready"},  32'(in_ready),  32'(ir));
    endtask

    function automatic vec_t mk(input bit rst, input bit iv, input int s, input bit ordy,
                                input int lvl, input bit ov, input int dat,
                                input bit err, input bit ir);
        vec_t v;
        v.rst = rst; v.iv = iv; v.s = SW'(s); v.ordy = ordy;
        v.lvl = 2'(lvl); v.ov = ov; v.dat = W'(dat); v.err = err; v.ir = ir;
        return v;
    endfunction

    // Fixed channel pattern: channel k carries 16'hA000 + k.
    task automatic load_fixed_channels();
        for (int k = 0; k < N; k++) hyrjet[k*W +: W] = W'(16'hA000 + k);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        S         = '0;
        load_fixed_channels();

        // Reset, select sweep, out-of-range selects, empty pop, backpressure,
        // pop-only at full, and push+pop at occupancy one.
        //         rst iv  s ordy  lvl ov  dalja     g  ir
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1,  0, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1,  1, 1, 16'hA000, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1,  1, 1, 16'hA001, 0, 1));
        vecs.push_back(mk(0, 1, 2, 1,  1, 1, 16'hA002, 0, 1));
        vecs.push_back(mk(0, 1, 3, 1,  1, 1, 16'hA003, 0, 1));
        vecs.push_back(mk(0, 1, 4, 1,  1, 1, 16'hA004, 0, 1));
        vecs.push_back(mk(0, 1, 5, 1,  1, 1, 16'h0000, 1, 1));
        vecs.push_back(mk(0, 1, 6, 1,  1, 1, 16'h0000, 1, 1));
        vecs.push_back(mk(0, 1, 7, 1,  1, 1, 16'h0000, 1, 1));
        vecs.push_back(mk(0, 1, 2, 1,  1, 1, 16'hA002, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0,  1, 1, 16'hA001, 0, 1));
        vecs.push_back(mk(0, 1, 3, 0,  2, 1, 16'hA001, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  2, 1, 16'hA001, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  2, 1, 16'hA001, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 1, 16'hA003, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 1, 4, 0,  1, 1, 16'hA004, 0, 1));
        vecs.push_back(mk(0, 1, 5, 0,  2, 1, 16'hA004, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  1, 1, 16'h0000, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1,  1, 1, 16'hA001, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0, 16'h0000, 0, 1));

        foreach (vecs[i]) begin
            Reset     = vecs[i].rst;
            in_valid  = vecs[i].iv;
            S         = vecs[i].s;
            out_ready = vecs[i].ordy;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].ov,
                       vecs[i].dat, vecs[i].err, vecs[i].ir);
        end

        // Sustained push+pop at occupancy one: one result per cycle, in order.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            S = SW'(i % N);
            tick();
            check_outs($sformatf("stream%0d", i), 2'd1, 1'b1,
                       W'(16'hA000 + (i % N)), 1'b0, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        check_outs("stream_drain", 2'd0, 1'b0, '0, 1'b0, 1'b1);

        // Reset while full discards both entries, and no stale data follows.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        S         = 3'd1;
        tick();
        S         = 3'd2;
        tick();
        check_outs("prefull", 2'd2, 1'b1, 16'hA001, 1'b0, 1'b0);
        Reset     = 1'b1;
        out_ready = 1'b1;
        S         = 3'd3;
        tick();
        check_outs("midrst", 2'd0, 1'b0, '0, 1'b0, 1'b1);
        Reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs($sformatf("post_rst%0d", i), 2'd0, 1'b0, '0, 1'b0, 1'b1);
        end

        // Randomized phase against the queue model.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        model_q.delete();
        for (int c = 0; c < 600; c++) begin
            bit   rnd_rst;
            bit   acc;
            bit   pp;
            ref_t ent;
            for (int k = 0; k < N; k++) hyrjet[k*W +: W] = W'($urandom);
            S         = SW'($urandom_range(0, (1 << SW) - 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rnd_rst   = ($urandom_range(0, 79) == 0);
            Reset     = rnd_rst;

            // Model: reset wins; otherwise pop the oldest entry and append the new one.
            acc   = in_valid && (model_q.size() < 2);
            pp    = out_ready && (model_q.size() > 0);
            ent.e = (int'(S) >= N);
            ent.d = ent.e ? '0 : hyrjet[int'(S)*W +: W];
            if (rnd_rst) begin
                model_q.delete();
            end else begin
                if (pp)  void'(model_q.pop_front());
                if (acc) model_q.push_back(ent);
            end

            tick();
            if (model_q.size() > 0)
                check_outs($sformatf("rnd%0d", c), 2'(model_q.size()), 1'b1,
                           model_q[0].d, model_q[0].e, model_q.size() < 2);
            else
                check_outs($sformatf("rnd%0d", c), 2'd0, 1'b0, '0, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
